// File: rtl/core_pkg.sv
// Shared core definitions: data width, default reset PC and the fetch queue entry.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered instruction: its PC, the returned word, and whether the word has arrived
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic            filled;
  } q_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory bus: req/gnt request channel plus in-order rvalid/rdata responses.
interface fetch_unit_if;

  logic                      req;
  logic [core_pkg::XLEN-1:0] addr;
  logic                      gnt;
  logic                      rvalid;
  logic [core_pkg::XLEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_queue.sv
// In-order ring buffer of fetch entries: allocate at tail, fill oldest unfilled, pop head, flush.
module fetch_queue
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  output q_entry_t        head,
  output logic [CW-1:0]   count,
  output logic [CW-1:0]   unfilled_count
);

  q_entry_t        mem_q [DEPTH];
  q_entry_t        mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [PW-1:0]   fill_q, fill_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   unf_q, unf_d;

  // Next-state for storage and pointers; fills always land in order, so one fill pointer suffices
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    unf_d   = unf_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
      unf_d   = '0;
    end else begin
      if (alloc) begin
        mem_d[tail_q] = '{pc: alloc_pc, data: '0, filled: 1'b0};
        tail_d        = tail_q + PW'(1);
      end
      if (fill) begin
        mem_d[fill_q].data   = fill_data;
        mem_d[fill_q].filled = 1'b1;
        fill_d               = fill_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(alloc) - CW'(pop);
      unf_d   = unf_q + CW'(alloc) - CW'(fill);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      unf_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      unf_q   <= unf_d;
    end
  end

  assign head           = mem_q[head_q];
  assign count          = count_q;
  assign unfilled_count = unf_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential requests, in-order buffering, redirect with stale-drop.
// Optional FETCH_PERF_EN adds perf_retired / perf_starve counters.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned     QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    imem,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst,
  input  logic            inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_retired,
  output logic [31:0]     perf_starve
`endif
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   q_count, q_unf;
  logic [CW:0]     in_use;
  q_entry_t        head;
  logic            req_c, accept, outstanding, rsp, fill, pop;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk            (clk),
    .rst            (rst),
    .flush          (redirect_valid),
    .alloc          (accept),
    .alloc_pc       (fetch_pc_q),
    .fill           (fill),
    .fill_data      (imem.rdata),
    .pop            (pop),
    .head           (head),
    .count          (q_count),
    .unfilled_count (q_unf)
  );

  // Request/response qualification; slots held by stale in-flight words still count as in use
  always_comb begin
    in_use      = {1'b0, q_count} + {1'b0, drop_q};
    req_c       = !rst && !halt && !redirect_valid && (in_use < (CW + 1)'(QUEUE_DEPTH));
    accept      = req_c && imem.gnt;
    outstanding = (drop_q != '0) || (q_unf != '0);
    rsp         = imem.rvalid && outstanding;
    fill        = rsp && (drop_q == '0) && !redirect_valid;
    inst_valid  = !rst && (q_count != '0) && head.filled;
    pop         = inst_valid && inst_ready && !redirect_valid;
    inst_pc     = rst ? '0 : head.pc;
    inst        = rst ? '0 : head.data;
  end

  assign imem.req  = req_c;
  assign imem.addr = fetch_pc_q;

  // Fetch PC and stale-response counter; a response in the redirect cycle is treated as stale
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d     = drop_q + q_unf - CW'(rsp);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  // Fetch state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] retired_q, retired_d, starve_q, starve_d;

  // Count delivered instructions and cycles where decode waited on an empty front end
  always_comb begin
    retired_d = retired_q + 32'(pop);
    starve_d  = starve_q + 32'(inst_ready && !inst_valid);
  end

  // Perf counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      starve_q  <= '0;
    end else begin
      retired_q <= retired_d;
      starve_q  <= starve_d;
    end
  end

  assign perf_retired = retired_q;
  assign perf_starve  = starve_q;
`endif

  a_rvalid_outstanding : assert property (@(posedge clk) disable iff (rst) imem.rvalid |-> outstanding);

endmodule
